// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execute unit with an iterative (1 bit/cycle) logical right shifter.
// Define ALU_FAST_SHIFT_EN to use a single-cycle barrel shifter for SRL/SRLV instead.
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [3:0]         ctrl_i,
  input  logic [WIDTH-1:0]   src1_i,
  input  logic [WIDTH-1:0]   src2_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [WIDTH-1:0]   result_o,
  output logic               zero_o,
  output logic               illegal_o
);

  typedef enum logic [3:0] {
    OP_AND   = 4'd0,
    OP_OR    = 4'd1,
    OP_NAND  = 4'd2,
    OP_NOR   = 4'd3,
    OP_ADDU  = 4'd4,
    OP_SUBU  = 4'd5,
    OP_SLT   = 4'd6,
    OP_EQUAL = 4'd7,
    OP_SRL   = 4'd8,
    OP_SRLV  = 4'd9
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

  state_e             state;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   opnd_nxt;
  logic [SHAMT_W-1:0] cnt;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_illegal;
  logic               shift_op;
  logic [SHAMT_W-1:0] shift_amt;
  logic               start_iter;

  assign opnd_nxt = opnd >> 1;

  always_comb begin
    alu_res     = '0;
    alu_illegal = 1'b0;
    shift_op    = 1'b0;
    shift_amt   = '0;
    start_iter  = 1'b0;
    case (ctrl_i)
      OP_AND:   alu_res = src1_i & src2_i;
      OP_OR:    alu_res = src1_i | src2_i;
      OP_NAND:  alu_res = ~(src1_i & src2_i);
      OP_NOR:   alu_res = ~(src1_i | src2_i);
      OP_ADDU:  alu_res = src1_i + src2_i;
      OP_SUBU:  alu_res = src1_i - src2_i;
      OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, $signed(src1_i) < $signed(src2_i)};
      OP_EQUAL: alu_res = {{(WIDTH-1){1'b0}}, src1_i == src2_i};
      OP_SRL: begin
        shift_op  = 1'b1;
        shift_amt = shamt_i;
      end
      OP_SRLV: begin
        shift_op  = 1'b1;
        shift_amt = src1_i[SHAMT_W-1:0];
      end
      default:  alu_illegal = 1'b1;
    endcase
`ifdef ALU_FAST_SHIFT_EN
    if (shift_op) alu_res = src2_i >> shift_amt;
`else
    // A zero-count shift completes directly with the unshifted operand.
    if (shift_op) alu_res = src2_i;
    start_iter = shift_op && (shift_amt != '0);
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      result_o  <= '0;
      zero_o    <= 1'b1;
      illegal_o <= 1'b0;
      cnt       <= '0;
      opnd      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            busy_o <= 1'b1;
            if (start_iter) begin
              state <= S_SHIFT;
              opnd  <= src2_i;
              cnt   <= shift_amt;
            end else begin
              state     <= S_DONE;
              done_o    <= 1'b1;
              result_o  <= alu_res;
              zero_o    <= (alu_res == '0);
              illegal_o <= alu_illegal;
            end
          end
        end
        S_SHIFT: begin
          // The final shift and the move to DONE share an edge, giving n+1 latency.
          opnd <= opnd_nxt;
          cnt  <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state     <= S_DONE;
            done_o    <= 1'b1;
            result_o  <= opnd_nxt;
            zero_o    <= (opnd_nxt == '0);
            illegal_o <= 1'b0;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases plus random ops against
// an arithmetic reference model. Honours ALU_FAST_SHIFT_EN for shift latency.
module tb_alu_exec_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [3:0]  ctrl_i;
  logic [31:0] src1_i;
  logic [31:0] src2_i;
  logic [4:0]  shamt_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic        zero_o;
  logic        illegal_o;

`ifdef ALU_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .ctrl_i    (ctrl_i),
    .src1_i    (src1_i),
    .src2_i    (src2_i),
    .shamt_i   (shamt_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .result_o  (result_o),
    .zero_o    (zero_o),
    .illegal_o (illegal_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: result, illegal flag and done latency from plain arithmetic.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] sh, output logic [31:0] r, output bit ill,
                                output int lat);
    longint ua = {32'd0, a};
    longint ub = {32'd0, b};
    longint sa = $signed(a);
    longint sb = $signed(b);
    longint m  = 64'h1_0000_0000;
    longint n;
    ill = 1'b0;
    lat = 1;
    r   = '0;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: r = ~(a & b);
      4'd3: r = ~(a | b);
      4'd4: r = 32'((ua + ub) % m);
      4'd5: r = 32'((ua - ub + m) % m);
      4'd6: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd7: r = (ua == ub) ? 32'd1 : 32'd0;
      4'd8, 4'd9: begin
        n = (op == 4'd8) ? longint'(sh) : (ua % 32);
        r = 32'(ub / (longint'(1) << n));
        if (n != 0 && !FAST) lat = int'(n) + 1;
      end
      default: begin
        r   = '0;
        ill = 1'b1;
      end
    endcase
  endfunction

  // Issue one op from IDLE (called at a negedge), check latency, outputs and pulse width.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh);
    logic [31:0] er;
    bit          eill;
    int          elat;
    int          lat;
    model(op, a, b, sh, er, eill, elat);
    start_i = 1'b1;
    ctrl_i  = op;
    src1_i  = a;
    src2_i  = b;
    shamt_i = sh;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    ctrl_i  = 4'($urandom);
    src1_i  = $urandom;
    src2_i  = $urandom;
    shamt_i = 5'($urandom);
    lat = 1;
    while (done_o !== 1'b1 && lat < 200) begin
      @(negedge clk_i);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(elat));
    chk({tag, "_res"}, result_o, er);
    chk({tag, "_zero"}, 32'(zero_o), 32'(er == 32'd0));
    chk({tag, "_ill"}, 32'(illegal_o), 32'(eill));
    chk({tag, "_busy"}, 32'(busy_o), 32'd1);
    @(negedge clk_i);
    chk({tag, "_pulse"}, 32'(done_o), 32'd0);
    chk({tag, "_idle"}, 32'(busy_o), 32'd0);
    chk({tag, "_hold"}, result_o, er);
  endtask

  initial begin
    int pulses;
    logic [31:0] er;
    bit eill;
    int elat;
    int lat;

    rst_i   = 1'b1;
    start_i = 1'b0;
    ctrl_i  = '0;
    src1_i  = '0;
    src2_i  = '0;
    shamt_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_res", result_o, 32'd0);
    chk("rst_zero", 32'(zero_o), 32'd1);
    chk("rst_ill", 32'(illegal_o), 32'd0);

    run_op("addu_wrap", 4'd4, 32'hFFFF_FFFF, 32'd1, 5'd0);
    run_op("slt_neg", 4'd6, 32'hFFFF_FFFE, 32'd1, 5'd0);
    run_op("subu_neg", 4'd5, 32'd5, 32'd7, 5'd0);
    run_op("srl_31", 4'd8, 32'h1234_5678, 32'h8000_0000, 5'd31);
    run_op("srlv_0", 4'd9, 32'hABCD_EF20, 32'hDEAD_BEEF, 5'd7);
    run_op("eq_true", 4'd7, 32'h5A5A_0001, 32'h5A5A_0001, 5'd0);

    // start_i held high through a shift by 4: second request taken after IDLE returns.
    model(4'd8, 32'd0, 32'h0000_00F0, 5'd4, er, eill, elat);
    start_i = 1'b1;
    ctrl_i  = 4'd8;
    src1_i  = 32'd0;
    src2_i  = 32'h0000_00F0;
    shamt_i = 5'd4;
    @(posedge clk_i);
    @(negedge clk_i);
    ctrl_i = 4'd4;
    src1_i = 32'd10;
    src2_i = 32'd20;
    lat = 1;
    while (done_o !== 1'b1 && lat < 200) begin
      @(negedge clk_i);
      lat++;
    end
    chk("hold_lat", 32'(lat), 32'(elat));
    chk("hold_res", result_o, er);
    @(negedge clk_i);
    chk("hold_idle_done", 32'(done_o), 32'd0);
    chk("hold_idle_busy", 32'(busy_o), 32'd0);
    @(negedge clk_i);
    start_i = 1'b0;
    chk("hold_second_done", 32'(done_o), 32'd1);
    chk("hold_second_res", result_o, 32'd30);
    @(negedge clk_i);
    chk("hold_second_pulse", 32'(done_o), 32'd0);

    // Reset on the 3rd cycle of a shift by 10, with start_i asserted alongside reset.
    pulses  = 0;
    start_i = 1'b1;
    ctrl_i  = 4'd8;
    src1_i  = 32'd0;
    src2_i  = 32'hFFFF_0000;
    shamt_i = 5'd10;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pulses += int'(done_o);
      @(negedge clk_i);
    end
    pulses += int'(done_o);
    rst_i   = 1'b1;
    start_i = 1'b1;
    ctrl_i  = 4'd4;
    src1_i  = 32'd1;
    src2_i  = 32'd1;
    @(negedge clk_i);
    rst_i   = 1'b0;
    start_i = 1'b0;
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_done", 32'(done_o), 32'd0);
    chk("abort_res", result_o, 32'd0);
    chk("abort_zero", 32'(zero_o), 32'd1);
    chk("abort_ill", 32'(illegal_o), 32'd0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      pulses += int'(done_o);
    end
    chk("abort_pulses", 32'(pulses), FAST ? 32'd1 : 32'd0);
    run_op("after_abort", 4'd4, 32'd2, 32'd3, 5'd0);

    run_op("illegal_12", 4'd12, 32'h1357_9BDF, 32'h2468_ACE0, 5'd3);
    run_op("and_clears", 4'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0);

    for (int i = 0; i < 40; i++) begin
      run_op("rand", 4'($urandom_range(0, 15)), $urandom, $urandom, 5'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset, named clk_i and rst_i.
REQ-002 Parameter WIDTH, default 32, SHALL set the operand and result width.
REQ-003 Parameter SHAMT_W, default 5, SHALL set the shift-count width; WIDTH SHALL equal 2**SHAMT_W.
REQ-004 clk_i  input  1  rising-edge clock.
REQ-005 rst_i  input  1  synchronous reset, active high.
REQ-006 start_i  input  1  request; sampled only in IDLE.
REQ-007 ctrl_i  input  4  operation code from the ALU control decoder.
REQ-008 src1_i  input  WIDTH  operand rs.
REQ-009 src2_i  input  WIDTH  operand rt.
REQ-010 shamt_i  input  SHAMT_W  constant shift amount.
REQ-011 busy_o  output  1  unit not IDLE.
REQ-012 done_o  output  1  one-cycle result-valid pulse.
REQ-013 result_o  output  WIDTH  registered result.
REQ-014 zero_o  output  1  result_o == 0.
REQ-015 illegal_o  output  1  last accepted ctrl_i was undefined.

Function
REQ-016 Op codes SHALL be: AND=0, OR=1, NAND=2, NOR=3, ADDU=4, SUBU=5, SLT=6, EQUAL=7, SRL=8 (src2 >> shamt_i), SRLV=9 (src2 >> src1[SHAMT_W-1:0]).
REQ-017 Codes 10-15 SHALL be illegal; result 0, illegal_o=1, latency 1.
REQ-018 ADDU and SUBU SHALL wrap modulo 2**WIDTH, with no overflow flag.
REQ-019 SLT SHALL be a signed two's-complement compare: result 1 if src1<src2, else 0.
REQ-020 EQUAL SHALL give result 1 if src1==src2, else 0.
REQ-021 SRL and SRLV SHALL be logical shifts with zero fill.
REQ-022 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-023 A request SHALL be accepted on a rising edge in IDLE with start_i=1; all inputs SHALL be captured at that edge.
REQ-024 Non-shift op, or shift with count 0: IDLE -> DONE at the accept edge, with result loaded.
REQ-025 Shift with count n>0: IDLE -> SHIFT, with the operand and count n loaded.
REQ-026 SHIFT state, each edge: operand >> 1, count - 1; go to DONE when count reaches 0.
REQ-027 DONE -> IDLE unconditionally after one cycle.
REQ-028 done_o SHALL be 1 only in DONE, so it pulses for exactly one cycle.
REQ-029 busy_o SHALL be 1 in SHIFT and DONE.
REQ-030 Latency from accept edge to done_o high SHALL be 1 cycle for non-shift ops and n+1 cycles for a shift by n.
REQ-031 start_i SHALL be ignored while busy_o=1, with no queuing; throughput is at most one op per 2 cycles.
REQ-032 result_o, zero_o and illegal_o SHALL update only when done_o rises and SHALL hold until the next completion.
REQ-033 Inputs other than start_i SHALL be don't-care after the accept edge.

Reset
REQ-034 rst_i=1 at an edge SHALL force: state IDLE, busy_o=0, done_o=0, result_o=0, zero_o=1, illegal_o=0, count=0.
REQ-035 Reset mid-SHIFT or in DONE SHALL abort the operation with no done_o pulse; start_i in the same cycle as reset SHALL be ignored.

Configuration
REQ-036 Macro ALU_FAST_SHIFT_EN defined: SRL and SRLV SHALL use a combinational barrel shifter, take the non-shift path (latency 1), and SHIFT SHALL be unreachable.
REQ-037 Macro ALU_FAST_SHIFT_EN undefined: the iterative shifter of REQ-025 and REQ-026 SHALL be used; all other behaviour SHALL be identical.

Verification
REQ-038 Reset, then ADDU src1=0xFFFFFFFF, src2=1 -> done_o 1 cycle later, result_o=0, zero_o=1, busy_o high 1 cycle.
REQ-039 SLT src1=0xFFFFFFFE (-2), src2=1 -> result_o=1; SUBU 5-7 -> result_o=0xFFFFFFFE, zero_o=0.
REQ-040 SRL src2=0x80000000, shamt=31 -> done_o exactly 32 cycles after accept (1 cycle with ALU_FAST_SHIFT_EN), result_o=1; SRLV with src1[4:0]=0 -> result_o=src2 at latency 1.
REQ-041 start_i held high during a shift by 4 -> only the first request executes; the second is accepted on the first edge after return to IDLE.
REQ-042 rst_i asserted on the 3rd cycle of a shift by 10 -> no done_o pulse, outputs at reset values, next ADDU 2+3 gives 5.
REQ-043 ctrl_i=12 -> illegal_o=1, result_o=0, zero_o=1 at latency 1; a following AND clears illegal_o.
